// File: rtl/apple1_text_pkg.sv
// rtl/apple1_text_pkg.sv - shared types, ASCII constants and byte translation for the text injector
package apple1_text_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, GAP} state_t;

    localparam logic [6:0] ASCII_LF  = 7'h0A;
    localparam logic [6:0] ASCII_CR  = 7'h0D;
    localparam logic [6:0] ASCII_ESC = 7'h1B;

    localparam logic [1:0] LF_PASS     = 2'd0;
    localparam logic [1:0] LF_TO_CR    = 2'd1;
    localparam logic [1:0] LF_DROP     = 2'd2;
    localparam logic [1:0] LF_COLLAPSE = 2'd3;

    typedef struct packed {
        logic       keep;
        logic [6:0] chr;
    } xlat_t;

    function automatic xlat_t translate(input logic [6:0] c, input logic upcase_en,
                                        input logic [1:0] lf_mode, input logic prev_cr);
        xlat_t r;
        r.keep = 1'b0;
        r.chr  = c;
        if (c == ASCII_LF) begin
            case (lf_mode)
                LF_PASS:  r.keep = 1'b1;
                LF_TO_CR: begin r.keep = 1'b1; r.chr = ASCII_CR; end
                LF_DROP:  r.keep = 1'b0;
                default:  begin r.keep = !prev_cr; r.chr = ASCII_CR; end
            endcase
        end else if (c == ASCII_CR || c == ASCII_ESC) begin
            r.keep = 1'b1;
        end else if (c >= 7'h61 && c <= 7'h7A) begin
            r.keep = 1'b1;
            if (upcase_en) r.chr = c - 7'h20;
        end else if (c >= 7'h20 && c <= 7'h5F) begin
            r.keep = 1'b1;
        end else if (c >= 7'h60 && c <= 7'h7E) begin
            // backtick, braces, bar and tilde have no upper-case twin on the Apple-I
            r.keep = !upcase_en;
        end
        return r;
    endfunction

endpackage

// File: rtl/text_fifo.sv
// rtl/text_fifo.sv - synchronous FIFO with flush; head entry readable without a pop
module text_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full      = count[AW];
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    // a flush cycle still accepts the byte arriving with it, as entry 0
    assign do_push   = push & (flush | ~full);
    assign do_pop    = pop & ~empty & ~flush;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = {{AW{1'b0}}, push};
        else if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (!do_push && do_pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= {{(AW-1){1'b0}}, push};
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ioctl_text_injector.sv
// rtl/ioctl_text_injector.sv - paces downloaded ASCII text into the Apple-I keyboard register
module ioctl_text_injector #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16,
    parameter int CHAR_GAP   = 25000,
    parameter int LINE_GAP   = 250000
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              upcase_en,
    input  logic [1:0]        lf_mode,
    output logic [6:0]        kbd_data,
    output logic              kbd_valid,
    input  logic              kbd_ack,
    output logic              busy,
    output logic              overflow
);
    import apple1_text_pkg::*;

    localparam int GAP_MAX = (CHAR_GAP > LINE_GAP) ? CHAR_GAP : LINE_GAP;
    localparam int TW      = $clog2(GAP_MAX + 1);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_next;
    logic          dl_prev;
    logic          dl_rise;
    logic [TW-1:0] gap_timer;
    logic          prev_cr;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [6:0]    fifo_head;
    logic [CW-1:0] fifo_count_next;
    logic          present_load;
    logic          gap_load;
    xlat_t         xl;

    wire unused_inputs = &{1'b0, ioctl_addr, ioctl_dout[7]};

    assign dl_rise   = ioctl_download & ~dl_prev;
    assign fifo_push = ioctl_wr & ioctl_download;
    assign xl        = translate(fifo_head, upcase_en, lf_mode, prev_cr);
    assign busy      = ~fifo_empty | (state != IDLE);

    text_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(7)) u_fifo (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .flush      (dl_rise),
        .push       (fifo_push),
        .push_data  (ioctl_dout[6:0]),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count_next (fifo_count_next)
    );

    always_ff @(posedge clk25) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        present_load = 1'b0;
        gap_load     = 1'b0;
        if (dl_rise) begin
            state_next = FETCH;
        end else begin
            case (state)
                IDLE: ;
                FETCH: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (xl.keep) begin
                            present_load = 1'b1;
                            state_next   = PRESENT;
                        end
                    end else if (!ioctl_download) begin
                        state_next = IDLE;
                    end
                end
                PRESENT: begin
                    if (kbd_ack) begin
                        gap_load   = 1'b1;
                        state_next = GAP;
                    end
                end
                GAP:     if (gap_timer == '0) state_next = FETCH;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            dl_prev    <= 1'b0;
            gap_timer  <= '0;
            prev_cr    <= 1'b0;
            kbd_data   <= '0;
            kbd_valid  <= 1'b0;
            overflow   <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            // from the next count so the slack covers hps_io's in-flight writes
            ioctl_wait <= (fifo_count_next >= CW'(FIFO_DEPTH - 2));
            if (dl_rise) begin
                overflow  <= 1'b0;
                kbd_valid <= 1'b0;
                prev_cr   <= 1'b0;
                gap_timer <= '0;
            end else begin
                if (fifo_push && fifo_full) overflow <= 1'b1;
                if (present_load) begin
                    kbd_data  <= xl.chr;
                    kbd_valid <= 1'b1;
                    prev_cr   <= (xl.chr == ASCII_CR);
                end
                if (gap_load) begin
                    kbd_valid <= 1'b0;
                    gap_timer <= (kbd_data == ASCII_CR) ? TW'(LINE_GAP) : TW'(CHAR_GAP);
                end else if (state == GAP && gap_timer != '0) begin
                    gap_timer <= gap_timer - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ioctl_text_injector.sv
// tb/tb_ioctl_text_injector.sv - directed self-checking bench for ioctl_text_injector
module tb_ioctl_text_injector;

    localparam int CHAR_GAP = 4;
    localparam int LINE_GAP = 20;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        upcase_en;
    logic [1:0]  lf_mode;
    logic [6:0]  kbd_data;
    logic        kbd_valid;
    logic        kbd_ack;
    logic        busy;
    logic        overflow;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ioctl_text_injector #(
        .FIFO_DEPTH (16),
        .ADDR_W     (16),
        .CHAR_GAP   (CHAR_GAP),
        .LINE_GAP   (LINE_GAP)
    ) dut (
        .clk25          (clk25),
        .rst_n          (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .upcase_en      (upcase_en),
        .lf_mode        (lf_mode),
        .kbd_data       (kbd_data),
        .kbd_valid      (kbd_valid),
        .kbd_ack        (kbd_ack),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk25 = ~clk25;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        ioctl_addr = ioctl_addr + 16'd1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) write_byte(s[i]);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        ioctl_addr     = '0;
        tick();
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!kbd_valid && n < 1000) begin
            tick();
            n++;
        end
        check({tag, " valid"}, kbd_valid, 1);
    endtask

    task automatic expect_char(input string tag, input logic [6:0] exp, output int n);
        wait_valid(tag, n);
        check({tag, " data"}, kbd_data, exp);
        kbd_ack = 1'b1;
        tick();
        kbd_ack = 1'b0;
        check({tag, " valid drop"}, kbd_valid, 0);
    endtask

    task automatic expect_quiet(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (kbd_valid) seen = 1'b1;
            tick();
        end
        check({tag, " no extra char"}, seen, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int          n;
        int          written;
        int          rcv;
        int          errs;
        int          wait_at;
        int          cyc;
        logic [6:0]  last;
        logic [6:0]  exp1 [9];

        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        upcase_en      = 1'b1;
        lf_mode        = 2'd1;
        kbd_ack        = 1'b0;
        repeat (3) tick();
        check("reset kbd_valid", kbd_valid, 0);
        check("reset kbd_data", kbd_data, 0);
        check("reset ioctl_wait", ioctl_wait, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // lowercase exercises upcase folding; LF becomes CR
        exp1 = '{7'h31, 7'h30, 7'h20, 7'h50, 7'h52, 7'h49, 7'h4E, 7'h54, 7'h0D};
        start_download();
        send("10 print\n");
        ioctl_download = 1'b0;
        for (int i = 0; i < 9; i++) begin
            expect_char($sformatf("t1 char%0d", i), exp1[i], n);
            if (i == 1) check("t1 char gap", n, CHAR_GAP + 2);
        end
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("t1 line gap to idle", n, LINE_GAP + 2);

        // honour ioctl_wait while the CPU drains
        written = 0; rcv = 0; errs = 0; wait_at = -1; cyc = 0;
        start_download();
        while (rcv < 40 && cyc < 4000) begin
            ioctl_wr = 1'b0;
            kbd_ack  = 1'b0;
            if (ioctl_wait && wait_at < 0) wait_at = written;
            if (written < 40 && !ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_dout = 8'h30 + 8'(written);
                written++;
            end
            if (wait_at >= 0 && kbd_valid) begin
                if (kbd_data != 7'h30 + 7'(rcv)) errs++;
                rcv++;
                kbd_ack = 1'b1;
            end
            tick();
            cyc++;
        end
        ioctl_wr = 1'b0; kbd_ack = 1'b0; ioctl_download = 1'b0;
        check("t2 wait rises at 15 writes", wait_at, 15);
        check("t2 all received", rcv, 40);
        check("t2 order errors", errs, 0);
        check("t2 no overflow", overflow, 0);
        expect_quiet("t2a");

        // ignore ioctl_wait: 1 presented + 16 buffered, rest dropped
        start_download();
        for (int i = 0; i < 40; i++) write_byte(8'h30 + 8'(i));
        check("t2b overflow", overflow, 1);
        check("t2b wait", ioctl_wait, 1);
        check("t2b first presented", kbd_data, 7'h30);
        ioctl_download = 1'b0;
        rcv = 0; cyc = 0; last = '0;
        while (busy && cyc < 2000) begin
            kbd_ack = kbd_valid;
            if (kbd_valid) begin
                last = kbd_data;
                rcv++;
            end
            tick();
            cyc++;
        end
        kbd_ack = 1'b0;
        check("t2b received", rcv, 17);
        check("t2b last char", last, 7'h40);

        // CRLF collapse
        lf_mode = 2'd3;
        start_download();
        check("t3 overflow cleared", overflow, 0);
        send("A\r\nB\nC");
        ioctl_download = 1'b0;
        expect_char("t3 A", 7'h41, n);
        expect_char("t3 CR1", 7'h0D, n);
        expect_char("t3 B", 7'h42, n);
        expect_char("t3 CR2", 7'h0D, n);
        expect_char("t3 C", 7'h43, n);
        expect_quiet("t3a");

        // lowercase passes without upcase, BEL dropped, LF passed in mode 0
        upcase_en = 1'b0;
        lf_mode   = 2'd0;
        start_download();
        write_byte(8'h61);
        write_byte(8'h07);
        write_byte(8'h62);
        write_byte(8'h0A);
        ioctl_download = 1'b0;
        expect_char("t3 a", 7'h61, n);
        expect_char("t3 b", 7'h62, n);
        expect_char("t3 LF", 7'h0A, n);
        expect_quiet("t3b");
        upcase_en = 1'b1;
        lf_mode   = 2'd1;

        // stray acks during GAP and FETCH
        start_download();
        send("XYZ");
        ioctl_download = 1'b0;
        expect_char("t4 X", 7'h58, n);
        tick();
        kbd_ack = 1'b1;
        tick();
        kbd_ack = 1'b0;
        expect_char("t4 Y", 7'h59, n);
        repeat (5) tick();
        kbd_ack = 1'b1;
        tick();
        kbd_ack = 1'b0;
        check("t4 Z presented", kbd_valid, 1);
        check("t4 Z data", kbd_data, 7'h5A);
        tick();
        check("t4 Z still held", kbd_valid, 1);
        expect_char("t4 Z", 7'h5A, n);
        check("t4 Z immediate", n, 0);
        expect_quiet("t4");

        // restart mid-PRESENT
        start_download();
        send("PQR");
        wait_valid("t5 P", n);
        check("t5 P data", kbd_data, 7'h50);
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        check("t5 valid falls", kbd_valid, 0);
        send("JK");
        ioctl_download = 1'b0;
        expect_char("t5 J", 7'h4A, n);
        expect_char("t5 K", 7'h4B, n);
        expect_quiet("t5");

        // reset during GAP with bytes still buffered
        start_download();
        send("STUV");
        expect_char("t6 S", 7'h53, n);
        tick();
        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        tick();
        check("t6 kbd_valid", kbd_valid, 0);
        check("t6 kbd_data", kbd_data, 0);
        check("t6 ioctl_wait", ioctl_wait, 0);
        check("t6 busy", busy, 0);
        check("t6 overflow", overflow, 0);
        rst_n = 1'b1;
        expect_quiet("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
